// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared size encodings, FSM state type and byte-lane helpers for
//           the wait-state data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Offset bits below natural alignment are ignored, which aligns down.
    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram_array.sv
// ============================================================================
// Module  : dmem_sram_array
// Brief   : DEPTH_WORDS x 32 storage, synchronous byte-enabled write and
//           asynchronous read. Contents are never reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
            always_ff @(posedge clk) begin
                if (we && be[g]) begin
                    mem_q[addr][8*g +: 8] <= wdata[8*g +: 8];
                end
            end
        end
    endgenerate

    assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/dmem_wait.sv
// ============================================================================
// Module  : dmem_wait
// Brief   : Single-outstanding data memory with WAIT_CYCLES wait states and
//           byte/half/word loads and stores. DMEM_MISALIGN_TRAP_EN makes
//           misaligned half/word accesses an error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic [31:0] rdata_q;
    logic        rerr_q;

    logic          w_accept;
    logic          w_oor;
    logic          w_misalign;
    logic          w_req_err;
    logic          op_exec;
    logic          op_we;
    logic [AW-1:0] op_idx;
    logic [1:0]    op_off;
    logic [1:0]    op_size;
    logic          op_uns;
    logic [31:0]   op_wdata;
    logic          op_err;
    logic [31:0]   w_mem_rdata;

    assign w_accept = req_valid && (state_q == IDLE);
    assign w_oor    = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = w_oor || (req_size == SZ_RSVD) || w_misalign;

    // With no wait states the operation happens on the accept edge itself,
    // so it must use the live request rather than the latched copy.
    generate
        if (WAIT_CYCLES == 0) begin : g_zero_wait
            assign op_exec  = w_accept;
            assign op_we    = req_we;
            assign op_idx   = req_addr[AW+1:2];
            assign op_off   = req_addr[1:0];
            assign op_size  = req_size;
            assign op_uns   = req_unsigned;
            assign op_wdata = req_wdata;
            assign op_err   = w_req_err;
        end else begin : g_wait_states
            assign op_exec  = (state_q == WAIT) && (cnt_q == 4'd0);
            assign op_we    = we_q;
            assign op_idx   = idx_q;
            assign op_off   = off_q;
            assign op_size  = size_q;
            assign op_uns   = uns_q;
            assign op_wdata = wdata_q;
            assign op_err   = err_q;
        end
    endgenerate

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (op_exec && op_we && !op_err),
        .be    (lane_be(op_size, op_off)),
        .addr  (op_idx),
        .wdata (store_lanes(op_size, op_wdata)),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= req_we;
                idx_q   <= req_addr[AW+1:2];
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                err_q   <= w_req_err;
            end
            if (op_exec) begin
                rdata_q <= (op_we || op_err) ? 32'd0
                                             : load_extend(op_size, op_off, op_uns, w_mem_rdata);
                rerr_q  <= op_err;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

endmodule

`default_nettype wire
